// File: rtl/mmio_peripheral_hub.sv
// mmio_peripheral_hub
//   Small memory-mapped peripheral block for a soft CPU. It provides a free
//   running timer with a compare interrupt, a serial RX FIFO, a serial TX
//   holding register, a synchronised game-pad input and a bank of display
//   registers. Everything sits in one 16-word window starting at BASE_ADDR.
//
//   Offset map: 0 TIME (R/W), 1 CMP (R/W), 2 STATUS (R/W1C), 3 SERIAL_RX (R),
//               4 SERIAL_TX (W), 5 GAMEPAD (R), 8.. VREG[0..NUM_VREG-1] (R/W)
//
// Ports
//   Clock, Reset                  rising-edge clock, async active-low reset
//   Addr, WrData, WrEn, RdEn      CPU bus request
//   RdData                        registered read data, zero when not reading
//   Hit                           combinational decode of Addr
//   SerialValid, SerialDataIn     RX word strobe and data (pushed into FIFO)
//   SerialSend, SerialDataOut     one-cycle TX pulse and held TX word
//   GamePad                       asynchronous button inputs
//   VReg                          packed display registers
//   TimerIrq, FifoOverflow        sticky STATUS bits 3 and 2
module mmio_peripheral_hub #(
  parameter int                DATA_W     = 16,
  parameter int                NUM_VREG   = 2,
  parameter int                FIFO_DEPTH = 4,
  parameter int                PRESCALE   = 1,
  parameter logic [DATA_W-1:0] BASE_ADDR  = 16'hFF00
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [DATA_W-1:0]          Addr,
  input  logic [DATA_W-1:0]          WrData,
  input  logic                       WrEn,
  input  logic                       RdEn,
  output logic [DATA_W-1:0]          RdData,
  output logic                       Hit,
  input  logic                       SerialValid,
  input  logic [DATA_W-1:0]          SerialDataIn,
  output logic                       SerialSend,
  output logic [DATA_W-1:0]          SerialDataOut,
  input  logic [7:0]                 GamePad,
  output logic [NUM_VREG*DATA_W-1:0] VReg,
  output logic                       TimerIrq,
  output logic                       FifoOverflow
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  localparam logic [3:0] OFF_TIME    = 4'd0;
  localparam logic [3:0] OFF_CMP     = 4'd1;
  localparam logic [3:0] OFF_STATUS  = 4'd2;
  localparam logic [3:0] OFF_RX      = 4'd3;
  localparam logic [3:0] OFF_TX      = 4'd4;
  localparam logic [3:0] OFF_GAMEPAD = 4'd5;

  logic [DATA_W-1:0] time_q, cmp_q, rd_data_q, tx_data_q;
  logic [15:0]       presc_q;
  logic              irq_q, ovf_q, send_q;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [7:0]        gp_meta_q, gp_sync_q;
  logic [DATA_W-1:0] vreg_q [NUM_VREG];

  logic [3:0]        offset;
  logic              wr_hit, rd_hit;
  logic              time_wr, cmp_wr, status_wr, tx_wr;
  logic              tick, match_set;
  logic [DATA_W-1:0] time_next;
  logic              fifo_empty, fifo_full, pop, push_ok, ovf_set;
  logic [DATA_W-1:0] rd_mux;

  // Address decode: the upper bits select the window, the low nibble the
  // register. A write on the same cycle as a read wins and suppresses the read
  // (and therefore any FIFO pop).
  always_comb begin
    offset    = Addr[3:0];
    Hit       = (Addr[DATA_W-1:4] == BASE_ADDR[DATA_W-1:4]) &&
                ((offset <= OFF_GAMEPAD) ||
                 ((offset >= 4'd8) && (int'(offset) < 8 + NUM_VREG)));
    wr_hit    = WrEn && Hit;
    rd_hit    = RdEn && Hit && !WrEn;
    time_wr   = wr_hit && (offset == OFF_TIME);
    cmp_wr    = wr_hit && (offset == OFF_CMP);
    status_wr = wr_hit && (offset == OFF_STATUS);
    tx_wr     = wr_hit && (offset == OFF_TX);

    // A TIME write restarts the prescaler, so it never ticks in that cycle.
    tick      = !time_wr && (presc_q == PRE_LAST);
    time_next = time_q + 1'b1;
    match_set = tick && (time_next == cmp_q);

    // A push into a full FIFO is only accepted when a pop frees a slot in the
    // same cycle; otherwise the word is dropped and flagged.
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    pop        = rd_hit && (offset == OFF_RX) && !fifo_empty;
    push_ok    = SerialValid && (!fifo_full || pop);
    ovf_set    = SerialValid && fifo_full && !pop;
  end

  // Read multiplexer; write-only and unimplemented offsets read as zero.
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_TIME:    rd_mux = time_q;
      OFF_CMP:     rd_mux = cmp_q;
      OFF_STATUS:  rd_mux[3:0] = {irq_q, ovf_q, fifo_full, !fifo_empty};
      OFF_RX:      rd_mux = fifo_empty ? '0 : mem[rd_ptr_q];
      OFF_GAMEPAD: rd_mux[7:0] = gp_sync_q;
      default: begin
        for (int i = 0; i < NUM_VREG; i++) begin
          if (offset == 4'(8 + i)) rd_mux = vreg_q[i];
        end
      end
    endcase
  end

  // Timer, compare register and the two sticky status flags. Set events take
  // precedence over a write-one-to-clear in the same cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      time_q  <= '0;
      presc_q <= '0;
      cmp_q   <= '1;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (time_wr) begin
        time_q  <= WrData;
        presc_q <= '0;
      end else if (tick) begin
        time_q  <= time_next;
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      if (cmp_wr) cmp_q <= WrData;
      if (match_set)                    irq_q <= 1'b1;
      else if (status_wr && WrData[3])  irq_q <= 1'b0;
      if (ovf_set)                      ovf_q <= 1'b1;
      else if (status_wr && WrData[2])  ovf_q <= 1'b0;
    end
  end

  // RX FIFO bookkeeping; the storage array itself needs no reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr_q] <= SerialDataIn;
  end

  // Bus read register, TX holding register, game-pad synchroniser and
  // display registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_data_q <= '0;
      tx_data_q <= '0;
      send_q    <= 1'b0;
      gp_meta_q <= '0;
      gp_sync_q <= '0;
      for (int i = 0; i < NUM_VREG; i++) vreg_q[i] <= '0;
    end else begin
      rd_data_q <= rd_hit ? rd_mux : '0;
      send_q    <= tx_wr;
      if (tx_wr) tx_data_q <= WrData;
      gp_meta_q <= GamePad;
      gp_sync_q <= gp_meta_q;
      for (int i = 0; i < NUM_VREG; i++) begin
        if (wr_hit && (offset == 4'(8 + i))) vreg_q[i] <= WrData;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_VREG; g++) begin : g_vreg
      assign VReg[g*DATA_W +: DATA_W] = vreg_q[g];
    end
  endgenerate

  assign RdData        = rd_data_q;
  assign SerialSend    = send_q;
  assign SerialDataOut = tx_data_q;
  assign TimerIrq      = irq_q;
  assign FifoOverflow  = ovf_q;

endmodule

// File: tb/tb_mmio_peripheral_hub.sv
// tb_mmio_peripheral_hub
//   Testbench for mmio_peripheral_hub. A default instance (PRESCALE=1) is
//   driven cycle by cycle against a behavioural model built from a queue and
//   plain arithmetic; a second instance with PRESCALE=3 exercises TIME wrap.
module tb_mmio_peripheral_hub;

  localparam int          DW      = 16;
  localparam int          NV      = 2;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] BASE    = 16'hFF00;
  localparam logic [11:0] BASE_HI = 12'hFF0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] addr, wr_data, serial_data_in;
  logic        wr_en, rd_en, serial_valid;
  logic [7:0]  game_pad;
  logic [15:0] rd_data, serial_data_out;
  logic        hit, serial_send, timer_irq, fifo_overflow;
  logic [31:0] vreg;

  logic [15:0] p3_addr, p3_wr_data, p3_serial_data_in;
  logic        p3_wr_en, p3_rd_en, p3_serial_valid;
  logic [7:0]  p3_game_pad;
  logic [15:0] p3_rd_data, p3_serial_data_out;
  logic        p3_hit, p3_serial_send, p3_timer_irq, p3_fifo_overflow;
  logic [31:0] p3_vreg;

  mmio_peripheral_hub #(.DATA_W(DW), .NUM_VREG(NV), .FIFO_DEPTH(DEPTH),
                        .PRESCALE(1), .BASE_ADDR(BASE)) dut (
    .Clock(clk), .Reset(rst_n), .Addr(addr), .WrData(wr_data), .WrEn(wr_en),
    .RdEn(rd_en), .RdData(rd_data), .Hit(hit), .SerialValid(serial_valid),
    .SerialDataIn(serial_data_in), .SerialSend(serial_send),
    .SerialDataOut(serial_data_out), .GamePad(game_pad), .VReg(vreg),
    .TimerIrq(timer_irq), .FifoOverflow(fifo_overflow)
  );

  mmio_peripheral_hub #(.DATA_W(DW), .NUM_VREG(NV), .FIFO_DEPTH(DEPTH),
                        .PRESCALE(3), .BASE_ADDR(BASE)) dut_p3 (
    .Clock(clk), .Reset(rst_n), .Addr(p3_addr), .WrData(p3_wr_data),
    .WrEn(p3_wr_en), .RdEn(p3_rd_en), .RdData(p3_rd_data), .Hit(p3_hit),
    .SerialValid(p3_serial_valid), .SerialDataIn(p3_serial_data_in),
    .SerialSend(p3_serial_send), .SerialDataOut(p3_serial_data_out),
    .GamePad(p3_game_pad), .VReg(p3_vreg), .TimerIrq(p3_timer_irq),
    .FifoOverflow(p3_fifo_overflow)
  );

  // Reference model state
  logic [15:0] m_time, m_cmp, m_tx, m_rd;
  logic        m_irq, m_ovf, m_send;
  logic [15:0] m_vreg [NV];
  logic [7:0]  m_gp1, m_gp2;
  logic [15:0] m_fifo [$];

  int checks = 0;
  int errors = 0;

  logic [7:0]  gp_level;
  logic [15:0] r_addr, r_wd, r_sd;
  logic        r_we, r_re, r_sv;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_impl(input logic [15:0] a);
    logic [3:0] o;
    o = a[3:0];
    return (a[15:4] == BASE_HI) &&
           ((o <= 4'd5) || ((o >= 4'd8) && (int'(o) < 8 + NV)));
  endfunction

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s = '0;
    s[0] = (m_fifo.size() != 0);
    s[1] = (m_fifo.size() == DEPTH);
    s[2] = m_ovf;
    s[3] = m_irq;
    return s;
  endfunction

  task automatic resetModel();
    m_time = '0; m_cmp = 16'hFFFF; m_tx = '0; m_rd = '0;
    m_irq = 1'b0; m_ovf = 1'b0; m_send = 1'b0;
    m_gp1 = '0; m_gp2 = '0;
    m_fifo.delete();
    for (int i = 0; i < NV; i++) m_vreg[i] = '0;
  endtask

  // One bus cycle: drive at the falling edge, predict the next state from the
  // register-level rules, then compare all outputs just after the rising edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] wd,
                               input logic we, input logic re, input logic sv,
                               input logic [15:0] sd);
    logic       impl, wr, rd, popped, was_full, cmp_hit;
    int         off;
    logic [15:0] nt;
    @(negedge clk);
    addr = a; wr_data = wd; wr_en = we; rd_en = re;
    serial_valid = sv; serial_data_in = sd; game_pad = gp_level;
    #1;
    impl = is_impl(a);
    off  = int'(a[3:0]);
    checkOutput("hit", {31'b0, hit}, {31'b0, impl});
    wr = we && impl;
    rd = re && impl && !we;

    m_rd = '0;
    if (rd) begin
      case (off)
        0: m_rd = m_time;
        1: m_rd = m_cmp;
        2: m_rd = model_status();
        3: if (m_fifo.size() > 0) m_rd = m_fifo[0];
        5: m_rd = {8'h00, m_gp2};
        default: if (off >= 8) m_rd = m_vreg[off-8];
      endcase
    end

    cmp_hit = 1'b0;
    if (wr && off == 0) m_time = wd;
    else begin
      nt      = m_time + 16'd1;
      cmp_hit = (nt == m_cmp);
      m_time  = nt;
    end
    if (wr && off == 1) m_cmp = wd;
    if (wr && off == 2) begin
      if (wd[2]) m_ovf = 1'b0;
      if (wd[3]) m_irq = 1'b0;
    end
    if (cmp_hit) m_irq = 1'b1;

    was_full = (m_fifo.size() == DEPTH);
    popped   = rd && off == 3 && m_fifo.size() > 0;
    if (popped) void'(m_fifo.pop_front());
    if (sv) begin
      if (!was_full || popped) m_fifo.push_back(sd);
      else m_ovf = 1'b1;
    end

    m_send = wr && off == 4;
    if (m_send) m_tx = wd;
    if (wr && off >= 8) m_vreg[off-8] = wd;
    m_gp2 = m_gp1;
    m_gp1 = gp_level;

    @(posedge clk);
    #1;
    checkOutput("rd_data", {16'b0, rd_data}, {16'b0, m_rd});
    checkOutput("serial_send", {31'b0, serial_send}, {31'b0, m_send});
    checkOutput("serial_data_out", {16'b0, serial_data_out}, {16'b0, m_tx});
    checkOutput("vreg", vreg, {m_vreg[1], m_vreg[0]});
    checkOutput("timer_irq", {31'b0, timer_irq}, {31'b0, m_irq});
    checkOutput("fifo_overflow", {31'b0, fifo_overflow}, {31'b0, m_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask
  task automatic busWrite(input logic [3:0] off, input logic [15:0] d);
    applyStimulus(BASE + 16'(off), d, 1'b1, 1'b0, 1'b0, '0);
  endtask
  task automatic busRead(input logic [3:0] off);
    applyStimulus(BASE + 16'(off), '0, 1'b0, 1'b1, 1'b0, '0);
  endtask
  task automatic push(input logic [15:0] d);
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_data"}, {16'b0, rd_data}, 32'h0);
    checkOutput({tag, "_send"}, {31'b0, serial_send}, 32'h0);
    checkOutput({tag, "_tx_data"}, {16'b0, serial_data_out}, 32'h0);
    checkOutput({tag, "_vreg"}, vreg, 32'h0);
    checkOutput({tag, "_irq"}, {31'b0, timer_irq}, 32'h0);
    checkOutput({tag, "_ovf"}, {31'b0, fifo_overflow}, 32'h0);
  endtask

  initial begin
    addr = '0; wr_data = '0; wr_en = 0; rd_en = 0; serial_valid = 0;
    serial_data_in = '0; game_pad = '0; gp_level = '0;
    p3_addr = '0; p3_wr_data = '0; p3_wr_en = 0; p3_rd_en = 0;
    p3_serial_valid = 0; p3_serial_data_in = '0; p3_game_pad = '0;
    resetModel();
    #1 rst_n = 1'b0;
    #11;
    checkAllZero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // CMP resets to all-ones
    busRead(4'd1);
    checkOutput("cmp_reset", {16'b0, rd_data}, 32'hFFFF);

    // Compare match two edges after TIME=3 with CMP=5, then W1C
    busWrite(4'd1, 16'd5);
    busWrite(4'd0, 16'd3);
    checkOutput("irq_after_time_wr", {31'b0, timer_irq}, 32'h0);
    idle(1);
    checkOutput("irq_one_edge", {31'b0, timer_irq}, 32'h0);
    idle(1);
    checkOutput("irq_two_edges", {31'b0, timer_irq}, 32'h1);
    busWrite(4'd2, 16'h0008);
    checkOutput("irq_cleared", {31'b0, timer_irq}, 32'h0);

    // Overfill the FIFO, then drain it
    push(16'hA0A0); push(16'hB1B1); push(16'hC2C2); push(16'hD3D3); push(16'hE4E4);
    busRead(4'd2);
    checkOutput("status_full_ovf", {16'b0, rd_data}, 32'h0007);
    busRead(4'd3); checkOutput("rx_A", {16'b0, rd_data}, 32'hA0A0);
    busRead(4'd3); checkOutput("rx_B", {16'b0, rd_data}, 32'hB1B1);
    busRead(4'd3); checkOutput("rx_C", {16'b0, rd_data}, 32'hC2C2);
    busRead(4'd3); checkOutput("rx_D", {16'b0, rd_data}, 32'hD3D3);
    busRead(4'd3); checkOutput("rx_empty", {16'b0, rd_data}, 32'h0);
    busWrite(4'd2, 16'h0004);
    checkOutput("ovf_cleared", {31'b0, fifo_overflow}, 32'h0);

    // Push and pop together while full
    push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
    applyStimulus(BASE + 16'd3, '0, 1'b0, 1'b1, 1'b1, 16'h5555);
    checkOutput("full_pushpop_rd", {16'b0, rd_data}, 32'h1111);
    checkOutput("full_pushpop_ovf", {31'b0, fifo_overflow}, 32'h0);
    busRead(4'd2);
    checkOutput("full_pushpop_status", {16'b0, rd_data}, 32'h0003);
    busRead(4'd3); busRead(4'd3); busRead(4'd3);
    busRead(4'd3); checkOutput("rx_tail", {16'b0, rd_data}, 32'h5555);

    // Serial TX pulse and display register
    busWrite(4'd4, 16'h1234);
    checkOutput("tx_send", {31'b0, serial_send}, 32'h1);
    checkOutput("tx_data", {16'b0, serial_data_out}, 32'h1234);
    idle(1);
    checkOutput("tx_send_low", {31'b0, serial_send}, 32'h0);
    busWrite(4'd9, 16'hBEEF);
    checkOutput("vreg1", {16'b0, vreg[31:16]}, 32'hBEEF);

    // Unimplemented offsets and foreign addresses
    busWrite(4'd6, 16'h1111); busRead(4'd6);
    busRead(4'd7); busWrite(4'd10, 16'h2222); busRead(4'd10);
    applyStimulus(16'hFE01, 16'h0BAD, 1'b1, 1'b0, 1'b0, '0);
    busRead(4'd1);
    checkOutput("cmp_untouched", {16'b0, rd_data}, 32'h0005);

    // Write wins over a simultaneous read, with no FIFO pop
    applyStimulus(BASE + 16'd8, 16'h7777, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("wr_priority_rd", {16'b0, rd_data}, 32'h0);
    push(16'h6666);
    applyStimulus(BASE + 16'd3, 16'h0, 1'b1, 1'b1, 1'b0, '0);
    busRead(4'd3);
    checkOutput("no_pop_on_wr", {16'b0, rd_data}, 32'h6666);

    // Game pad through the synchroniser
    gp_level = 8'h5A;
    idle(2);
    busRead(4'd5);
    checkOutput("gamepad", {16'b0, rd_data}, 32'h005A);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      r_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                           : BASE + 16'($urandom_range(0, 15));
      r_wd = 16'($urandom);
      r_sd = 16'($urandom);
      r_we = ($urandom_range(0, 9) < 3);
      r_re = ($urandom_range(0, 9) < 4);
      r_sv = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 19) == 0) gp_level = 8'($urandom);
      applyStimulus(r_addr, r_wd, r_we, r_re, r_sv, r_sd);
    end

    // Reset asserted mid-pop while SerialSend is high
    idle(1);
    push(16'h0A0A); push(16'h0B0B);
    busWrite(4'd4, 16'hCAFE);
    @(negedge clk);
    addr = BASE + 16'd3; rd_en = 1'b1; wr_en = 1'b0; serial_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("midpop_reset");
    resetModel();
    rd_en = 1'b0; addr = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    busRead(4'd1);
    checkOutput("cmp_after_reset", {16'b0, rd_data}, 32'hFFFF);
    busRead(4'd2);
    checkOutput("status_after_reset", {16'b0, rd_data}, 32'h0);
    busRead(4'd3);
    checkOutput("rx_after_reset", {16'b0, rd_data}, 32'h0);

    // TIME wrap with PRESCALE=3 on the second instance
    p3_addr = BASE; p3_wr_data = 16'hFFFF; p3_wr_en = 1'b1;
    idle(1);
    p3_wr_en = 1'b0; p3_rd_en = 1'b1;
    idle(1); checkOutput("p3_time_e1", {16'b0, p3_rd_data}, 32'hFFFF);
    idle(1); checkOutput("p3_time_e2", {16'b0, p3_rd_data}, 32'hFFFF);
    idle(1); checkOutput("p3_time_e3", {16'b0, p3_rd_data}, 32'hFFFF);
    idle(1); checkOutput("p3_time_wrapped", {16'b0, p3_rd_data}, 32'h0);
    checkOutput("p3_no_irq", {31'b0, p3_timer_irq}, 32'h0);
    p3_rd_en = 1'b0;
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_peripheral_hub.md
MMIO_PERIPHERAL_HUB -- requirements
Module: mmio_peripheral_hub

Interface
REQ-001 SHALL have parameter DATA_W, default 16, bus and register width (min 8).
REQ-002 SHALL have parameter NUM_VREG, default 2, number of display registers (1-8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, serial RX FIFO entries (power of two, 2-16).
REQ-004 SHALL have parameter PRESCALE, default 1, clocks per timer tick (1-65535).
REQ-005 SHALL have parameter BASE_ADDR, default 16'hFF00, word address of offset 0, low 4 bits zero.
REQ-006 SHALL have ports: Clock  in  1  single clock, rising edge; Reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: Addr  in  DATA_W  word address; WrData  in  DATA_W  write data; WrEn  in  1  write strobe; RdEn  in  1  read strobe.
REQ-008 SHALL have ports: RdData  out  DATA_W  read data; Hit  out  1  Addr decodes to an implemented register (combinational).
REQ-009 SHALL have ports: SerialValid  in  1  RX word strobe; SerialDataIn  in  DATA_W  RX word; SerialSend  out  1  TX pulse; SerialDataOut  out  DATA_W  TX word.
REQ-010 SHALL have ports: GamePad  in  8  asynchronous buttons; VReg  out  NUM_VREG*DATA_W  display registers, VReg[i] at bits i*DATA_W+:DATA_W.
REQ-011 SHALL have ports: TimerIrq  out  1  level, equals STATUS bit 3; FifoOverflow  out  1  level, equals STATUS bit 2.

Function
REQ-012 SHALL decode offsets from BASE_ADDR: 0 TIME (R/W), 1 CMP (R/W), 2 STATUS (R/W1C), 3 SERIAL_RX (R), 4 SERIAL_TX (W), 5 GAMEPAD (R), 8..8+NUM_VREG-1 VREG (R/W).
REQ-013 SHALL assert Hit only for implemented offsets; unimplemented offsets read 0, ignore writes, and cause no side effects.
REQ-014 SHALL commit writes on the Clock edge where WrEn=1 and Hit=1.
REQ-015 SHALL present RdData registered, one cycle after RdEn=1 with Hit=1; RdData=0 in all other cycles.
REQ-016 SHALL give WrEn priority when WrEn and RdEn are both 1: write commits, read ignored, no FIFO pop, next-cycle RdData=0.
REQ-017 SHALL use a prescaler counting 0..PRESCALE-1; TIME increments by 1 on the wrap, modulo 2^DATA_W (all-ones -> 0).
REQ-018 SHALL, on a TIME write, load WrData and clear the prescaler; that cycle produces no tick.
REQ-019 SHALL set STATUS bit 3 on the edge where a tick makes TIME equal CMP; TIME/CMP writes never set it.
REQ-020 SHALL define STATUS bits: 0 FIFO non-empty, 1 FIFO full, 2 overflow (sticky), 3 timer match (sticky), others 0.
REQ-021 SHALL clear STATUS bits 2/3 when written with 1 in that bit; a set event in the same cycle wins over the clear.
REQ-022 SHALL push SerialDataIn into the FIFO on each edge with SerialValid=1.
REQ-023 SHALL pop the FIFO head on a SERIAL_RX read; RdData carries the popped word next cycle.
REQ-024 SHALL, on a SERIAL_RX read of an empty FIFO, return 0 and leave FIFO state unchanged.
REQ-025 SHALL, on a push while full without a same-cycle pop, drop the word and set STATUS bit 2.
REQ-026 SHALL, on simultaneous push and pop, perform both; count unchanged; no overflow even when full.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH and preserve FIFO order.
REQ-028 SHALL, on a SERIAL_TX write, register WrData onto SerialDataOut and pulse SerialSend high for exactly the next cycle; SerialDataOut holds until the next TX write.
REQ-029 SHALL synchronise GamePad through two flops; a GAMEPAD read returns the synchronised value zero-extended.

Reset
REQ-030 SHALL, while Reset=0, asynchronously clear TIME, prescaler, STATUS sticky bits, FIFO pointers and count, all VREG, SerialDataOut, GamePad synchroniser and RdData to 0; CMP resets to all-ones.
REQ-031 SHALL hold SerialSend, TimerIrq and FifoOverflow at 0 during reset; an in-flight pop, SerialSend pulse or tick is discarded.
REQ-032 SHALL, on the first edge after Reset=1, operate normally with no spurious push, pop or tick.

Verification
REQ-033 SHALL cover: PRESCALE=1, CMP=5, TIME=3 -> TimerIrq rises exactly 2 edges later; write STATUS 4'b1000 -> TimerIrq 0.
REQ-034 SHALL cover: FIFO_DEPTH=4, push 5 words A..E -> STATUS=4'b0111; four reads return A,B,C,D; fifth read returns 0.
REQ-035 SHALL cover: FIFO full plus SerialValid and SERIAL_RX read in the same cycle -> oldest returned, count stays 4, overflow stays 0.
REQ-036 SHALL cover: TIME=16'hFFFF with PRESCALE=3 -> TIME becomes 0 after exactly 3 edges; no irq unless CMP=0.
REQ-037 SHALL cover: write 16'h1234 to SERIAL_TX -> SerialSend high for one cycle, SerialDataOut=16'h1234; VREG[1] write appears on VReg bits 31:16.
REQ-038 SHALL cover: Reset=0 asserted mid-pop with SerialSend high -> all outputs 0 immediately, CMP=16'hFFFF, FIFO empty after release.
